// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single memory port between instruction fetch and the LSU.
// One transaction is in flight at a time: the winner of IDLE arbitration is
// latched, issued with word address / byte enables / lane-replicated store
// data, and its response is returned right-aligned and masked to its size.
// Misaligned data accesses never reach memory and complete with an error strobe.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata            fetch side
//   d_req/d_we/d_size/d_addr/d_wdata
//     -> d_gnt, d_rvalid, d_rdata, d_misaligned              data side
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata,
//     mem_gnt, mem_rvalid, mem_rdata                         memory port
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_t;

    state_t        state;
    logic [CW-1:0] starve_cnt;
    logic          src_fetch;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [3:0]    be_q;
    logic [31:0]   wdata_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic [31:0]   rdata_q;

    logic          d_mis;
    logic [3:0]    d_be;
    logic [31:0]   d_wlanes;
    logic          pick_if;
    logic          pick_d;
    logic [31:0]   rd_shift;
    logic [31:0]   rd_mask;

    // Fetch is word-aligned by construction; its low address bits carry nothing.
    logic unused_if_addr_lo;
    assign unused_if_addr_lo = ^if_addr[1:0];

    always_comb begin
        d_mis    = 1'b0;
        d_be     = 4'b1111;
        d_wlanes = d_wdata;
        case (d_size)
            2'b00: begin
                d_be     = 4'b0001 << d_addr[1:0];
                d_wlanes = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                d_be     = 4'b0011 << d_addr[1:0];
                d_wlanes = {2{d_wdata[15:0]}};
                d_mis    = d_addr[0];
            end
            2'b10:   d_mis = (d_addr[1:0] != 2'b00);
            default: d_mis = 1'b1;
        endcase
    end

    // Data normally wins; fetch wins outright once it has been passed over
    // STARVE_LIMIT times in a row.
    assign pick_if = if_req && (!d_req || starve_cnt == LIMIT);
    assign pick_d  = d_req && !pick_if;

    assign rd_shift = mem_rdata >> {off_q, 3'b000};
    always_comb begin
        rd_mask = rd_shift;
        case (size_q)
            2'b00:   rd_mask = {24'h0, rd_shift[7:0]};
            2'b01:   rd_mask = {16'h0, rd_shift[15:0]};
            default: rd_mask = rd_shift;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= '0;
            src_fetch  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            off_q      <= '0;
            size_q     <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_if) begin
                        src_fetch  <= 1'b1;
                        we_q       <= 1'b0;
                        addr_q     <= {if_addr[31:2], 2'b00};
                        be_q       <= 4'b1111;
                        wdata_q    <= '0;
                        off_q      <= 2'b00;
                        size_q     <= 2'b10;
                        starve_cnt <= '0;
                        state      <= REQ;
                    end else if (pick_d) begin
                        src_fetch <= 1'b0;
                        we_q      <= d_we;
                        addr_q    <= {d_addr[31:2], 2'b00};
                        be_q      <= d_be;
                        wdata_q   <= d_wlanes;
                        off_q     <= d_addr[1:0];
                        size_q    <= d_size;
                        if (if_req && starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + CW'(1);
                        state     <= d_mis ? ERR : REQ;
                    end
                end
                REQ:  if (mem_gnt) state <= WAIT;
                WAIT: if (mem_rvalid) begin
                    rdata_q <= rd_mask;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic in_req, in_resp, in_err;
    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);
    assign in_err  = (state == ERR);

    // Memory-side fields are only driven while a request is on the port.
    assign mem_req   = in_req;
    assign mem_we    = in_req & we_q;
    assign mem_be    = in_req ? be_q    : 4'b0000;
    assign mem_addr  = in_req ? addr_q  : 32'h0;
    assign mem_wdata = in_req ? wdata_q : 32'h0;

    assign if_gnt       = in_req & mem_gnt & src_fetch;
    assign d_gnt        = (in_req & mem_gnt & ~src_fetch) | in_err;
    assign if_rvalid    = in_resp & src_fetch;
    assign if_rdata     = (in_resp & src_fetch) ? rdata_q : 32'h0;
    assign d_rvalid     = (in_resp & ~src_fetch) | in_err;
    assign d_rdata      = (in_resp & ~src_fetch) ? rdata_q : 32'h0;
    assign d_misaligned = in_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized requesters/memory, all checked every cycle against a
// transaction-level model.
module tb_mem_port_arbiter;
    localparam int LIMIT = 4;

    logic        clk, rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid, d_misaligned;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_misaligned(d_misaligned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Snapshot of DUT outputs taken mid-cycle.
    logic        s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_d_mis, s_mem_req, s_mem_we;
    logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_mem_be;

    // Transaction-level model: the one accepted transaction and its progress.
    logic        m_busy, m_err, m_granted, m_have, m_fetch, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    int          m_off, m_size, m_starve;

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_granted = 0; m_have = 0; m_fetch = 0; m_we = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_be = 0;
        m_off = 0; m_size = 0; m_starve = 0;
    endtask

    task automatic model_step();
        int nbytes;
        logic [31:0] mask;
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (if_req && (!d_req || m_starve == LIMIT)) begin
                m_busy = 1; m_err = 0; m_granted = 0; m_have = 0;
                m_fetch = 1; m_we = 0; m_addr = if_addr & ~32'd3; m_be = 4'hF;
                m_wdata = 0; m_off = 0; m_size = 2; m_starve = 0;
            end else if (d_req) begin
                if (if_req && m_starve < LIMIT) m_starve++;
                m_busy = 1; m_granted = 0; m_have = 0; m_fetch = 0;
                m_we = d_we; m_addr = d_addr & ~32'd3;
                m_off = int'(d_addr % 4); m_size = int'(d_size);
                m_err = (m_size == 3) || ((d_addr % (32'd1 << m_size)) != 0);
                case (m_size)
                    0: begin m_be = 4'(1 << m_off); m_wdata = (d_wdata & 32'hFF) * 32'h01010101; end
                    1: begin m_be = 4'(3 << m_off); m_wdata = (d_wdata & 32'hFFFF) * 32'h00010001; end
                    default: begin m_be = 4'hF; m_wdata = d_wdata; end
                endcase
            end
        end else if (m_err || m_have) begin
            m_busy = 0;
        end else if (!m_granted) begin
            if (mem_gnt) m_granted = 1;
        end else if (mem_rvalid) begin
            nbytes = 1 << m_size;
            mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
            m_rdata = (mem_rdata >> (8 * m_off)) & mask;
            m_have = 1;
        end
    endtask

    task automatic check_cycle();
        logic e_mreq, e_mwe, e_ig, e_iv, e_dg, e_dv, e_dm;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        e_mreq = 0; e_mwe = 0; e_ig = 0; e_iv = 0; e_dg = 0; e_dv = 0; e_dm = 0;
        e_be = 0; e_addr = 0; e_wd = 0; e_ird = 0; e_drd = 0;
        if (m_busy) begin
            if (m_err) begin
                e_dg = 1; e_dv = 1; e_dm = 1;
            end else if (!m_granted) begin
                e_mreq = 1; e_mwe = m_we; e_be = m_be; e_addr = m_addr; e_wd = m_wdata;
                if (mem_gnt) begin
                    if (m_fetch) e_ig = 1; else e_dg = 1;
                end
            end else if (m_have) begin
                if (m_fetch) begin e_iv = 1; e_ird = m_rdata; end
                else begin e_dv = 1; e_drd = m_rdata; end
            end
        end
        chk("mem_req", 32'(s_mem_req), 32'(e_mreq));
        chk("mem_we", 32'(s_mem_we), 32'(e_mwe));
        chk("mem_be", 32'(s_mem_be), 32'(e_be));
        chk("mem_addr", s_mem_addr, e_addr);
        if (e_mwe) chk("mem_wdata", s_mem_wdata, e_wd);
        chk("if_gnt", 32'(s_if_gnt), 32'(e_ig));
        chk("if_rvalid", 32'(s_if_rvalid), 32'(e_iv));
        chk("if_rdata", s_if_rdata, e_ird);
        chk("d_gnt", 32'(s_d_gnt), 32'(e_dg));
        chk("d_rvalid", 32'(s_d_rvalid), 32'(e_dv));
        chk("d_misaligned", 32'(s_d_mis), 32'(e_dm));
        chk("d_rdata", s_d_rdata, e_drd);
    endtask

    // Inputs for a cycle are set just after its rising edge; outputs are
    // sampled and compared at the falling edge, then the model advances.
    task automatic tick();
        @(negedge clk);
        s_if_gnt = if_gnt; s_if_rvalid = if_rvalid; s_if_rdata = if_rdata;
        s_d_gnt = d_gnt; s_d_rvalid = d_rvalid; s_d_rdata = d_rdata; s_d_mis = d_misaligned;
        s_mem_req = mem_req; s_mem_we = mem_we; s_mem_be = mem_be;
        s_mem_addr = mem_addr; s_mem_wdata = mem_wdata;
        check_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w);
        d_we = we; d_size = sz; d_addr = a; d_wdata = w;
    endtask

    initial begin
        logic [9:0]  seq;
        logic [31:0] got;
        int ngr, nreq, nstable, nrv, found;
        logic ip, dp;

        rst_n = 0; if_req = 0; if_addr = 0; d_req = 0; set_d(0, 0, 0, 0);
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        model_reset();
        @(posedge clk); #1;
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        chk("rst_mem_req", 32'(s_mem_req), 0);
        chk("rst_mem_be", 32'(s_mem_be), 0);
        chk("rst_rvalid", 32'({s_if_rvalid, s_d_rvalid}), 0);
        rst_n = 1; mem_gnt = 0; mem_rvalid = 0;
        tick();

        // Single byte load at 0x103, zero-wait memory.
        set_d(0, 2'b00, 32'h103, 0); d_req = 1; mem_gnt = 1; mem_rvalid = 0;
        mem_rdata = 32'hAABBCCDD;
        tick();
        tick();
        chk("ld_mem_req", 32'(s_mem_req), 1);
        chk("ld_mem_addr", s_mem_addr, 32'h100);
        chk("ld_mem_be", 32'(s_mem_be), 32'h8);
        chk("ld_d_gnt", 32'(s_d_gnt), 1);
        d_req = 0; mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        tick();
        chk("ld_d_rvalid", 32'(s_d_rvalid), 1);
        chk("ld_d_rdata", s_d_rdata, 32'h000000AA);
        tick();

        // Half store at 0x202.
        set_d(1, 2'b01, 32'h202, 32'hFFFF1234); d_req = 1;
        tick();
        tick();
        chk("st_mem_we", 32'(s_mem_we), 1);
        chk("st_mem_be", 32'(s_mem_be), 32'hC);
        chk("st_mem_wdata", s_mem_wdata, 32'h12341234);
        d_req = 0; mem_rvalid = 1;
        tick();
        mem_rvalid = 0;
        tick();
        chk("st_d_rvalid", 32'(s_d_rvalid), 1);
        tick();

        // Misaligned word.
        set_d(0, 2'b10, 32'h301, 0); d_req = 1;
        tick();
        tick();
        chk("mis_mem_req", 32'(s_mem_req), 0);
        chk("mis_strobes", 32'({s_d_gnt, s_d_rvalid, s_d_mis}), 32'h7);
        chk("mis_d_rdata", s_d_rdata, 0);
        d_req = 0;
        tick();
        chk("mis_idle", 32'(s_d_rvalid), 0);

        // Contention: both requesters held continuously.
        set_d(0, 2'b10, 32'h700, 0); d_req = 1; if_req = 1; if_addr = 32'h800;
        mem_gnt = 1; mem_rvalid = 1; seq = 0; ngr = 0;
        for (int k = 0; k < 80 && ngr < 10; k++) begin
            tick();
            if (s_if_gnt || s_d_gnt) begin
                seq = {seq[8:0], s_if_gnt};
                ngr++;
            end
        end
        if_req = 0; d_req = 0;
        chk("cont_grants", 32'(ngr), 10);
        chk("cont_order", 32'(seq), 32'b0000100001);
        repeat (6) tick();

        // Stalls: grant late by 3 cycles, response late by 2, spurious rvalid in idle.
        nreq = 0; nstable = 0; nrv = 0; got = 0;
        for (int k = 0; k <= 12; k++) begin
            if_req = (k <= 4); if_addr = 32'h403;
            mem_gnt = !(k >= 1 && k <= 3);
            mem_rvalid = !(k == 5 || k == 6);
            mem_rdata = 32'hCAFE0000 | 32'(k);
            tick();
            if (s_mem_req) nreq++;
            if (s_mem_req && s_mem_addr == 32'h400 && s_mem_be == 4'hF && !s_mem_we) nstable++;
            nrv += int'(s_if_rvalid) + int'(s_d_rvalid);
            if (s_if_rvalid) got = s_if_rdata;
        end
        chk("stall_req_cycles", 32'(nreq), 4);
        chk("stall_stable", 32'(nstable), 4);
        chk("stall_rvalid_count", 32'(nrv), 1);
        chk("stall_rdata", got, 32'hCAFE0007);

        // Reset while waiting for a response.
        if_req = 1; if_addr = 32'h500; mem_gnt = 1; mem_rvalid = 0;
        tick();
        tick();
        if_req = 0;
        tick();
        rst_n = 0;
        #1;
        chk("rst_async_req", 32'(mem_req), 0);
        chk("rst_async_be", 32'(mem_be), 0);
        chk("rst_async_addr", mem_addr, 0);
        chk("rst_async_rv", 32'({if_rvalid, d_rvalid, if_gnt, d_gnt}), 0);
        model_reset();
        mem_rvalid = 1;
        tick();
        rst_n = 1;
        nrv = 0;
        repeat (3) begin
            tick();
            nrv += int'(s_if_rvalid) + int'(s_d_rvalid);
        end
        chk("rst_drop_pending", 32'(nrv), 0);
        if_req = 1; if_addr = 32'h600; mem_rdata = 32'h600D600D;
        found = 0; got = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            tick();
            if (s_if_gnt) if_req = 0;
            if (s_if_rvalid) begin found = 1; got = s_if_rdata; end
        end
        chk("rst_fetch_done", 32'(found), 1);
        chk("rst_fetch_data", got, 32'h600D600D);
        if_req = 0;
        tick();

        // Randomized traffic.
        ip = 0; dp = 0;
        for (int c = 0; c < 3000; c++) begin
            if (s_if_gnt) ip = 0;
            if (s_d_gnt) dp = 0;
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1; if_addr = $urandom;
            end
            if (!dp && $urandom_range(0, 2) != 0) begin
                dp = 1;
                set_d(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
            end
            if_req = ip; d_req = dp;
            mem_gnt = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the core's single memory port between instruction fetch and the load/store unit. It accepts one request at a time from either requester, generates word-aligned addresses, byte enables and lane-replicated store data, and runs a request/grant/response handshake with memory. It returns right-aligned load data; sign or zero extension stays in the LSU. It also detects misaligned data accesses and completes them locally, without touching memory.

## Interface
Parameters:
- STARVE_LIMIT, default 4: maximum consecutive data grants while fetch is waiting before fetch is forced to win.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- if_req  in  1  fetch request; held with if_addr until if_gnt.
- if_addr  in  32  fetch byte address.
- if_gnt  out  1  fetch request accepted by memory.
- if_rvalid  out  1  one-cycle fetch data strobe.
- if_rdata  out  32  fetch word.
- d_req  in  1  data request; held with the other d_* inputs until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-aligned.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  one-cycle data completion strobe; loads and stores alike.
- d_rdata  out  32  right-aligned load data; bits above the access size are 0.
- d_misaligned  out  1  qualifies d_rvalid: access rejected.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word address, {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response, for both reads and writes.
- mem_rdata  in  32  memory read word.

## Operation
- States: IDLE, REQ, WAIT, RESP, ERR. Only one transaction is outstanding at a time.
- IDLE arbitration:
  - If only one requester asserts req, it is selected.
  - If both assert req, data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - Increments (saturating) on each data selection made while if_req = 1.
  - Clears on each fetch selection.
- On selection, the block latches source, we, word address, be and wdata, then moves to REQ.
  - Exception: a misaligned data access goes to ERR instead.
- Misaligned data access is any of:
  - size 01 with addr[0] = 1;
  - size 10 with addr[1:0] != 0;
  - size 11.
- Byte enables:
  - byte: 4'b0001 << addr[1:0].
  - half: 4'b0011 << addr[1:0].
  - word: 4'b1111.
- Store data lanes:
  - byte: wdata[7:0] replicated ×4.
  - half: wdata[15:0] replicated ×2.
  - word: passed through unchanged.
- Fetch accesses are always word reads with be = 4'b1111. if_addr[1:0] is ignored.
- REQ:
  - mem_req = 1, with mem_we, mem_be, mem_addr and mem_wdata driven from the latched values.
  - When mem_gnt = 1, the selected requester's gnt is driven combinationally high for that cycle and the state moves to WAIT.
- WAIT: on mem_rvalid = 1, latch the shifted and masked read data and move to RESP.
  - Shift: mem_rdata >> (8 × addr[1:0]).
  - Mask by size: byte keeps [7:0], half keeps [15:0], word keeps [31:0].
- RESP: the selected requester's rvalid = 1 with the latched rdata; next state is IDLE.
- ERR: d_gnt = 1, d_rvalid = 1, d_misaligned = 1 and d_rdata = 0 in the same cycle; next state is IDLE. No memory access is made.
- mem_rvalid is ignored outside WAIT. mem_gnt is ignored outside REQ.

## Timing
- Reset (asynchronous):
  - State = IDLE and starve_cnt = 0.
  - All outputs are 0, including mem_be = 0 and all data buses = 0.
  - A memory response still pending when reset is released is dropped, because IDLE ignores mem_rvalid.
- Zero-wait memory, with a request seen in IDLE at cycle 0:
  - Cycle 1: mem_req and gnt (mem_gnt = 1).
  - Cycle 2: WAIT sees mem_rvalid.
  - Cycle 3: rvalid.
  - Cycle 4: IDLE; the next arbitration happens here.
  - Throughput is therefore one access per 4 cycles.
- mem_gnt stalls extend REQ, and mem_req stays high; response stalls extend WAIT.
- Misaligned access: request seen at cycle 0, ERR strobes at cycle 1, back to IDLE at cycle 2.
- Requester gnt is combinational from mem_gnt. All other outputs come from registered state.
- Requesters must deassert req in the cycle after gnt, unless they are issuing a new request.

## Test plan
- Single load: d_size = 00, d_addr = 0x103, mem_rdata = 0xAABBCCDD, zero wait.
  - Expected: mem_addr = 0x100, mem_be = 1000, d_rvalid at cycle 3 with d_rdata = 0x000000AA.
- Half store: d_size = 01, d_addr = 0x202, d_wdata = 0x1234.
  - Expected: mem_we = 1, mem_be = 1100, mem_wdata = 0x12341234, d_rvalid after mem_rvalid.
- Misaligned word: d_size = 10, d_addr = 0x301.
  - Expected: mem_req stays 0; at cycle 1, d_gnt = d_rvalid = d_misaligned = 1 and d_rdata = 0.
- Contention with STARVE_LIMIT = 4: if_req and d_req held continuously.
  - Expected grant order: D, D, D, D, I, D, D, D, D, I.
- Stalls: mem_gnt held low for 3 cycles, then mem_rvalid late by 2 cycles.
  - Expected: mem_req held 4 cycles, stable latched outputs, exactly one rvalid; a spurious mem_rvalid in IDLE is ignored.
- Reset asserted in WAIT.
  - Expected: outputs 0 immediately; after release, a pending mem_rvalid produces no rvalid, and a new fetch completes normally.
